// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : fpga_config_loader
// Description : Serial configuration loader. Hunts for a 16-bit sync word,
//               shifts in a CFG_BITS-bit payload while running a CRC-8
//               (poly 0x07), then receives an 8-bit CRC. On a CRC match the
//               payload is committed to cfg_out in a single cycle with a
//               one-cycle cfg_we pulse; on mismatch the live configuration
//               is left untouched and error is raised.
// Ports       : clock    - single clock, posedge
//               reset    - asynchronous, active-high
//               bs_data  - bitstream data, qualified by bs_valid
//               bs_valid - one valid bit per asserted cycle
//               abort    - synchronous abandon of any load in progress
//               cfg_out  - committed configuration bus (first bit at MSB)
//               cfg_we   - one-cycle pulse when cfg_out updates
//               done     - last frame committed successfully (held)
//               error    - last frame failed its CRC (held)
//               busy     - loading payload or receiving CRC
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_config_loader #(
  parameter int          CFG_BITS  = 539,
  parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bs_data,
  input  logic                bs_valid,
  input  logic                abort,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_we,
  output logic                done,
  output logic                error,
  output logic                busy
);

  // Wide enough to hold CFG_BITS itself, so power-of-two sizes never wrap.
  localparam int CW = $clog2(CFG_BITS + 1);

  localparam logic [CW-1:0] C_LAST_PAYLOAD = CW'(CFG_BITS - 1);
  localparam logic [CW-1:0] C_LAST_CRC     = CW'(7);
  localparam logic [7:0]    C_CRC_POLY     = 8'h07;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t                state_q,   state_d;
  logic [15:0]           win_q,     win_d;
  logic [CFG_BITS-1:0]   shadow_q,  shadow_d;
  logic [7:0]            crc_q,     crc_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]            rx_crc_q,  rx_crc_d;
  logic [CFG_BITS-1:0]   cfg_out_q, cfg_out_d;
  logic                  cfg_we_q,  cfg_we_d;
  logic                  done_q,    done_d;
  logic                  error_q,   error_d;
  logic                  busy_q,    busy_d;

  logic [15:0]           win_shift;
  logic [7:0]            crc_next;
  logic [7:0]            rx_crc_full;
  logic                  crc_fb;

  always_comb begin
    win_shift   = {win_q[14:0], bs_data};
    crc_fb      = crc_q[7] ^ bs_data;
    crc_next    = {crc_q[6:0], 1'b0} ^ (crc_fb ? C_CRC_POLY : 8'h00);
    // Received CRC including the bit being sampled this cycle.
    rx_crc_full = {rx_crc_q[6:0], bs_data};
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    shadow_d  = shadow_q;
    crc_d     = crc_q;
    bit_cnt_d = bit_cnt_q;
    rx_crc_d  = rx_crc_q;
    cfg_out_d = cfg_out_q;
    cfg_we_d  = 1'b0;
    done_d    = done_q;
    error_d   = error_q;

    if (abort) begin
      // Abort wins over any concurrent valid bit; that bit is dropped.
      state_d   = HUNT;
      win_d     = 16'h0000;
      bit_cnt_d = '0;
      crc_d     = 8'h00;
      done_d    = 1'b0;
      error_d   = 1'b0;
    end else if (bs_valid) begin
      case (state_q)
        HUNT, DONE, ERROR: begin
          win_d = win_shift;
          if (win_shift == SYNC_WORD) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
            crc_d     = 8'h00;
            win_d     = 16'h0000;
            done_d    = 1'b0;
            error_d   = 1'b0;
          end
        end
        LOAD: begin
          shadow_d  = {shadow_q[CFG_BITS-2:0], bs_data};
          crc_d     = crc_next;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == C_LAST_PAYLOAD) begin
            state_d   = CHECK;
            bit_cnt_d = '0;
          end
        end
        CHECK: begin
          rx_crc_d  = rx_crc_full;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == C_LAST_CRC) begin
            bit_cnt_d = '0;
            win_d     = 16'h0000;
            if (rx_crc_full == crc_q) begin
              cfg_out_d = shadow_q;
              cfg_we_d  = 1'b1;
              done_d    = 1'b1;
              state_d   = DONE;
            end else begin
              error_d   = 1'b1;
              state_d   = ERROR;
            end
          end
        end
        default: begin
          state_d = HUNT;
          win_d   = 16'h0000;
        end
      endcase
    end

    // Registered busy tracks the state being entered this edge.
    busy_d = (state_d == LOAD) || (state_d == CHECK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      win_q     <= 16'h0000;
      shadow_q  <= '0;
      crc_q     <= 8'h00;
      bit_cnt_q <= '0;
      rx_crc_q  <= 8'h00;
      cfg_out_q <= '0;
      cfg_we_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      shadow_q  <= shadow_d;
      crc_q     <= crc_d;
      bit_cnt_q <= bit_cnt_d;
      rx_crc_q  <= rx_crc_d;
      cfg_out_q <= cfg_out_d;
      cfg_we_q  <= cfg_we_d;
      done_q    <= done_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign cfg_out = cfg_out_q;
  assign cfg_we  = cfg_we_q;
  assign done    = done_q;
  assign error   = error_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_config_loader
// Description : Directed self-checking bench for fpga_config_loader with an
//               8-bit payload. Inputs change on the falling edge; outputs are
//               sampled on the falling edge after the sampling rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_config_loader;

  localparam int CFG_BITS = 8;

  logic                clock;
  logic                reset;
  logic                bs_data;
  logic                bs_valid;
  logic                abort;
  logic [CFG_BITS-1:0] cfg_out;
  logic                cfg_we;
  logic                done;
  logic                error;
  logic                busy;

  int vectors;
  int miscompares;
  int busy_total;
  int we_total;
  int snap_busy;
  int snap_we;

  fpga_config_loader #(
    .CFG_BITS  (CFG_BITS),
    .SYNC_WORD (16'hA55A)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bs_data  (bs_data),
    .bs_valid (bs_valid),
    .abort    (abort),
    .cfg_out  (cfg_out),
    .cfg_we   (cfg_we),
    .done     (done),
    .error    (error),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Running totals of cycles with busy / cfg_we high.
  initial begin
    busy_total = 0;
    we_total   = 0;
  end
  always @(negedge clock) begin
    if (busy === 1'b1)   busy_total = busy_total + 1;
    if (cfg_we === 1'b1) we_total   = we_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bs_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    bs_data  = b;
    bs_valid = 1'b1;
    @(negedge clock);
    bs_valid = 1'b0;
  endtask

  // Send the low n bits of v, MSB first, with 0..maxgap idle cycles before each.
  task automatic send_bits(input logic [31:0] v, input int n, input int maxgap);
    for (int i = n - 1; i >= 0; i--) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      send_bit(v[i]);
    end
  endtask

  // Full frame: sync word, payload, CRC.
  task automatic send_frame(input logic [7:0] payload, input logic [7:0] crc, input int maxgap);
    send_bits({16'h0000, 16'hA55A}, 16, maxgap);
    send_bits({24'h0, payload}, 8, maxgap);
    send_bits({24'h0, crc}, 8, maxgap);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bs_data     = 1'b0;
    bs_valid    = 1'b0;
    abort       = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset release with idle inputs: everything stays zero for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      check("reset_idle", {20'h0, cfg_out, cfg_we, done, error, busy}, 32'h0);
      @(negedge clock);
    end

    // Back-to-back frame A55A / 01 / CRC 07.
    snap_busy = busy_total;
    snap_we   = we_total;
    send_frame(8'h01, 8'h07, 0);
    check("s2_cfg_out",  {24'h0, cfg_out}, 32'h01);
    check("s2_cfg_we",   {31'h0, cfg_we},  32'h1);
    check("s2_done",     {31'h0, done},    32'h1);
    check("s2_error",    {31'h0, error},   32'h0);
    check("s2_busy_end", {31'h0, busy},    32'h0);
    idle(2);
    check("s2_we_drop",    {31'h0, cfg_we}, 32'h0);
    check("s2_done_held",  {31'h0, done},   32'h1);
    check("s2_busy_cycles", busy_total - snap_busy, 32'd16);
    check("s2_we_cycles",   we_total - snap_we,     32'd1);

    // Same frame with a bad CRC 06.
    snap_we = we_total;
    send_frame(8'h01, 8'h06, 0);
    check("s3_error",   {31'h0, error},   32'h1);
    check("s3_done",    {31'h0, done},    32'h0);
    check("s3_cfg_out", {24'h0, cfg_out}, 32'h01);
    idle(2);
    check("s3_we_cycles", we_total - snap_we, 32'd0);
    check("s3_err_held",  {31'h0, error},     32'h1);

    // Noise bits then the good frame with random idle gaps.
    snap_we = we_total;
    send_bits(32'h5, 3, 0);
    send_frame(8'h01, 8'h07, 5);
    check("s4_cfg_out", {24'h0, cfg_out}, 32'h01);
    check("s4_cfg_we",  {31'h0, cfg_we},  32'h1);
    check("s4_done",    {31'h0, done},    32'h1);
    check("s4_error",   {31'h0, error},   32'h0);
    idle(2);
    check("s4_we_cycles", we_total - snap_we, 32'd1);

    // Second frame aborted during its 4th CRC bit.
    send_bits({16'h0, 16'hA55A}, 16, 0);
    check("s5_busy_after_sync", {31'h0, busy}, 32'h1);
    check("s5_done_cleared",    {31'h0, done}, 32'h0);
    send_bits(32'h01, 8, 0);
    send_bits(32'h0, 3, 0);
    abort    = 1'b1;
    bs_data  = 1'b0;
    bs_valid = 1'b1;
    @(negedge clock);
    abort    = 1'b0;
    bs_valid = 1'b0;
    check("s5_abort_busy",    {31'h0, busy},    32'h0);
    check("s5_abort_done",    {31'h0, done},    32'h0);
    check("s5_abort_error",   {31'h0, error},   32'h0);
    check("s5_abort_cfg_out", {24'h0, cfg_out}, 32'h01);
    idle(3);
    send_frame(8'h00, 8'h00, 0);
    check("s5_zero_cfg_out", {24'h0, cfg_out}, 32'h00);
    check("s5_zero_done",    {31'h0, done},    32'h1);
    check("s5_zero_we",      {31'h0, cfg_we},  32'h1);
    idle(2);

    // Reload 01 so that reset has a nonzero configuration to clear.
    send_frame(8'h01, 8'h07, 0);
    check("s6_preload", {24'h0, cfg_out}, 32'h01);
    idle(2);

    // Reset asserted during the 5th payload bit.
    send_bits({16'h0, 16'hA55A}, 16, 0);
    send_bits(32'h0, 4, 0);
    bs_data  = 1'b0;
    bs_valid = 1'b1;
    reset    = 1'b1;
    #1;
    check("s6_reset_async", {20'h0, cfg_out, cfg_we, done, error, busy}, 32'h0);
    @(negedge clock);
    reset    = 1'b0;
    bs_valid = 1'b0;
    idle(2);
    check("s6_reset_idle", {20'h0, cfg_out, cfg_we, done, error, busy}, 32'h0);
    send_frame(8'h01, 8'h07, 0);
    check("s6_cfg_out", {24'h0, cfg_out}, 32'h01);
    check("s6_done",    {31'h0, done},    32'h1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
